// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync, blanking and strobes in the pixel clock domain.
// Optional vblank interrupt enabled by defining VGA_TIMING_IRQ_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_ce_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic        active_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        vblank_o,
  output logic        line_start_o,
  output logic        frame_start_o,
  output logic        irq_o,
  input  logic        irq_ack_i
);

  localparam logic [15:0] H_TOTAL   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_VIS     = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS     = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] x_nxt;
  logic [15:0] y_nxt;
  logic        active_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        vblank_nxt;
  logic        line_start_nxt;
  logic        frame_start_nxt;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    x_nxt = x_o;
    y_nxt = y_o;
    if (pix_ce_i) begin
      if (x_o == H_TOTAL - 16'd1) begin
        x_nxt = 16'd0;
        y_nxt = (y_o == V_TOTAL - 16'd1) ? 16'd0 : y_o + 16'd1;
      end else begin
        x_nxt = x_o + 16'd1;
      end
    end
  end

  // Outputs decode the next position so they line up with x_o/y_o in the same cycle.
  always_comb begin
    active_nxt      = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    vblank_nxt      = (y_nxt >= V_VIS);
    hs_nxt          = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt          = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VS_POL : ~VS_POL;
    line_start_nxt  = pix_ce_i && (x_nxt == 16'd0);
    frame_start_nxt = line_start_nxt && (y_nxt == 16'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_o           <= H_TOTAL - 16'd1;
      y_o           <= V_TOTAL - 16'd1;
      active_o      <= 1'b0;
      vblank_o      <= 1'b1;
      hs_o          <= ~HS_POL;
      vs_o          <= ~VS_POL;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      x_o           <= x_nxt;
      y_o           <= y_nxt;
      active_o      <= active_nxt;
      vblank_o      <= vblank_nxt;
      hs_o          <= hs_nxt;
      vs_o          <= vs_nxt;
      line_start_o  <= line_start_nxt;
      frame_start_o <= frame_start_nxt;
    end
  end

`ifdef VGA_TIMING_IRQ_EN
  logic irq_set;

  assign irq_set = line_start_nxt && (y_nxt == V_VIS);

  // A set on the same edge as an ack takes priority so no vblank entry is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else if (irq_set) begin
      irq_o <= 1'b1;
    end else if (irq_ack_i) begin
      irq_o <= 1'b0;
    end
  end
`else
  logic unused_irq_ack;

  assign unused_irq_ack = irq_ack_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 32x19 raster (16x12 visible).
// Driver pushes expected outputs per edge; monitor pops and compares one step after each edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Hand-computed raster: 16+4+6+6 = 32 pixels, 12+2+2+3 = 19 lines, 608 pixels per frame.
  localparam int HT    = 32;
  localparam int VT    = 19;
  localparam int FRAME = 608;
  localparam int HA    = 16;
  localparam int VA    = 12;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        active;
    logic        hs;
    logic        vs;
    logic        vblank;
    logic        ls;
    logic        fs;
    logic        irq;
  } obs_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pix_ce_i;
  logic        irq_ack_i;
  logic [15:0] x_o;
  logic [15:0] y_o;
  logic        active_o;
  logic        hs_o;
  logic        vs_o;
  logic        vblank_o;
  logic        line_start_o;
  logic        frame_start_o;
  logic        irq_o;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 1;

  // Model state: linear pixel index within the frame.
  int   n        = FRAME - 1;
  int   frame_ix = -1;
  logic m_ls     = 1'b0;
  logic m_fs     = 1'b0;
  logic m_irq    = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pix_ce_i     (pix_ce_i),
    .x_o          (x_o),
    .y_o          (y_o),
    .active_o     (active_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .vblank_o     (vblank_o),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o),
    .irq_o        (irq_o),
    .irq_ack_i    (irq_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int   x;
    int   y;
    x        = n % HT;
    y        = n / HT;
    o.x      = 16'(x);
    o.y      = 16'(y);
    o.active = (x < HA) && (y < VA);
    o.vblank = (y >= VA);
    o.hs     = !((x >= 20) && (x < 26));
    o.vs     = !((y >= 14) && (y < 16));
    o.ls     = m_ls;
    o.fs     = m_fs;
`ifdef VGA_TIMING_IRQ_EN
    o.irq    = m_irq;
`else
    o.irq    = 1'b0;
`endif
    return o;
  endfunction

  // One clock of stimulus, applied on the falling edge, with the model advanced to the next rising edge.
  task automatic step(input logic ce, input logic rst, input logic ack);
    @(negedge clk_i);
    rst_i     = rst;
    pix_ce_i  = ce;
    irq_ack_i = ack;
    if (rst) begin
      n     = FRAME - 1;
      m_ls  = 1'b0;
      m_fs  = 1'b0;
      m_irq = 1'b0;
    end else if (ce) begin
      n    = (n + 1) % FRAME;
      m_ls = (n % HT) == 0;
      m_fs = (n == 0);
      if (m_fs) frame_ix++;
      if (n == VA * HT) m_irq = 1'b1;
      else if (ack)     m_irq = 1'b0;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
      if (ack) m_irq = 1'b0;
    end
    exp_q.push_back(model_out());
  endtask

  // Monitor: compares every output one step after each rising edge and times frame strobes.
  initial begin : monitor
    obs_t act;
    obs_t req;
    int   cycle      = 0;
    int   last_fs    = -1;
    int   last_phase = 0;
    forever begin
      @(posedge clk_i);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        req = exp_q.pop_front();
        act = '{x_o, y_o, active_o, hs_o, vs_o, vblank_o, line_start_o, frame_start_o, irq_o};
        check("outputs", 64'(act), 64'(req));
      end
      if (frame_start_o) begin
        if (last_fs >= 0 && last_phase == phase)
          check("frame_period", 64'(cycle - last_fs), (phase == 2) ? 64'd1216 : 64'd608);
        last_fs    = cycle;
        last_phase = phase;
      end
    end
  end

  initial begin : driver
    rst_i     = 1'b1;
    pix_ce_i  = 1'b1;
    irq_ack_i = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);

    // Continuous pixels: ack at (10,12) in frame 0, ack coinciding with the set in frame 1.
    phase = 1;
    for (int i = 0; i < 3 * FRAME + 10; i++) begin
      logic ack;
      ack = ((n == VA * HT + 10) && (frame_ix == 0)) ||
            ((n == VA * HT - 1)  && (frame_ix == 1));
      step(1'b1, 1'b0, ack);
    end

    // Pixel clock at half rate.
    phase = 2;
    for (int i = 0; i < 2600; i++) step((i % 2) == 0, 1'b0, 1'b0);

    // Reset in mid-frame at (10,6).
    phase = 3;
    for (int i = 0; i < 2 * FRAME && n != 6 * HT + 10; i++) step(1'b1, 1'b0, 1'b0);
    check("reached_reset_point", 64'(n), 64'(6 * HT + 10));
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("async_reset", {x_o, y_o, active_o, vblank_o, hs_o, vs_o, line_start_o, frame_start_o},
          {16'd31, 16'd18, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);

    @(negedge clk_i);
    @(negedge clk_i);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
